// File: rtl/branch_redirect_ctrl_if.sv
// Fetch redirect handshake between the branch redirect controller and the
// instruction-cache front end.
//   redirect_valid : controller -> icache, corrected PC pending
//   redirect_pc    : controller -> icache, corrected fetch PC
//   redirect_ready : icache -> controller, redirect accepted this cycle
interface branch_redirect_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  redirect_valid;
    logic                  redirect_ready;
    logic [DATA_WIDTH-1:0] redirect_pc;

    modport master (output redirect_valid, output redirect_pc, input redirect_ready);
    modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Carries fetch-time branch predictions through D and E, compares them with the
// resolved outcome in execute, flushes younger stages on a mispredict and holds
// a fetch redirect until the icache accepts it. Keeps saturating perf counters.
//   clk, rst_n                       : clock, async active-low reset
//   valid_f, predict_taken_f,
//   branch_target_f                  : fetch-stage prediction
//   stall_d, stall_e                 : pipeline register holds
//   is_branch_e, is_jump_e, taken_e,
//   target_e, PC_e                   : execute-stage resolution
//   pc_sel_pred_f                    : fetch follows predicted target
//   flush_d, flush_e, fetch_hold     : pipeline control
//   branch_count, mispredict_count   : saturating perf counters
//   rif (master)                     : redirect valid/ready/pc handshake
module branch_redirect_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_f,
    input  logic                  predict_taken_f,
    input  logic [DATA_WIDTH-1:0] branch_target_f,
    input  logic                  stall_d,
    input  logic                  stall_e,
    input  logic                  is_branch_e,
    input  logic                  is_jump_e,
    input  logic                  taken_e,
    input  logic [DATA_WIDTH-1:0] target_e,
    input  logic [DATA_WIDTH-1:0] PC_e,
    output logic                  pc_sel_pred_f,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  fetch_hold,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count,
    branch_redirect_ctrl_if.master rif
);

    typedef enum logic {IDLE, REDIRECT} state_t;

    typedef struct packed {
        logic                  valid;
        logic                  taken;
        logic [DATA_WIDTH-1:0] target;
    } tag_t;

    state_t                state_q, state_d;
    tag_t                  d_tag_q, d_tag_d;
    tag_t                  e_tag_q, e_tag_d;
    logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0]  mispred_cnt_q, mispred_cnt_d;

    logic                  resolve;
    logic                  actual_taken;
    logic                  mispredict;
    logic [DATA_WIDTH-1:0] correct_pc;

    // Resolution datapath; ignored in REDIRECT since younger work is already flushed.
    always_comb begin
        actual_taken = is_jump_e | (is_branch_e & taken_e);
        resolve      = e_tag_q.valid & ~stall_e & (is_branch_e | is_jump_e) & (state_q == IDLE);
        mispredict   = resolve & ((actual_taken != e_tag_q.taken) |
                                  (actual_taken & e_tag_q.taken & (target_e != e_tag_q.target)));
        correct_pc   = actual_taken ? target_e : DATA_WIDTH'(PC_e + DATA_WIDTH'(4));
    end

    // Next-state, tag pipeline, counters and outputs.
    always_comb begin
        state_d       = state_q;
        d_tag_d       = d_tag_q;
        e_tag_d       = e_tag_q;
        redirect_pc_d = redirect_pc_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        flush_d       = 1'b0;
        flush_e       = 1'b0;
        fetch_hold    = 1'b0;
        pc_sel_pred_f = 1'b0;

        case (state_q)
            IDLE: begin
                pc_sel_pred_f = valid_f & predict_taken_f & ~mispredict;
                if (mispredict) begin
                    state_d       = REDIRECT;
                    redirect_pc_d = correct_pc;
                    flush_d       = 1'b1;
                    flush_e       = 1'b1;
                end
            end
            REDIRECT: begin
                flush_d    = 1'b1;
                flush_e    = 1'b1;
                fetch_hold = 1'b1;
                if (rif.redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over stall: the stage may hold its fields but loses validity.
        if (!stall_d) begin
            d_tag_d = '{valid: valid_f, taken: predict_taken_f, target: branch_target_f};
        end
        if (flush_d) begin
            d_tag_d.valid = 1'b0;
        end
        if (!stall_e) begin
            e_tag_d = d_tag_q;
        end
        if (flush_e) begin
            e_tag_d.valid = 1'b0;
        end

        if (resolve && (branch_cnt_q != {CNT_WIDTH{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
        end
        if (mispredict && (mispred_cnt_q != {CNT_WIDTH{1'b1}})) begin
            mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            d_tag_q       <= '0;
            e_tag_q       <= '0;
            redirect_pc_q <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            d_tag_q       <= d_tag_d;
            e_tag_q       <= e_tag_d;
            redirect_pc_q <= redirect_pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign rif.redirect_valid = (state_q == REDIRECT);
    assign rif.redirect_pc    = redirect_pc_q;
    assign branch_count       = branch_cnt_q;
    assign mispredict_count   = mispred_cnt_q;

endmodule
